// File: rtl/otp_stream_decryptor.sv
// Receive side of the one-time-pad link: regenerates the LFSR pad stream,
// checks the encryptor's pad index sequence and XORs ciphertext back to plaintext.
module otp_stream_decryptor #(
   parameter logic [7:0] SEED = 8'hA5,
   parameter logic [7:0] TAPS = 8'hB8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       resync,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [2:0] in_index,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [2:0] out_index,
   output logic       seq_err,
   output logic       busy,
   output logic       dbg_state
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
   localparam logic [7:0] LOAD = (SEED == 8'h00) ? 8'h01 : SEED;

   typedef enum logic {
      S_FILL = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t     state;
   logic [7:0] pad [8];
   logic [7:0] lfsr;
   logic [7:0] lfsr_next;
   logic [2:0] fill_cnt;
   logic [2:0] exp_idx;
   logic       accept;
   logic       idx_ok;

   assign lfsr_next = {lfsr[6:0], ^(lfsr & TAPS)};

   // Handshake: a byte transfers on any edge where in_valid && in_ready; in_ready
   // is only raised in RUN, with ena high, no resync, and room in the output register.
   assign in_ready  = (state == S_RUN) && ena && !resync && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign idx_ok    = (in_index == exp_idx);
   assign busy      = (state == S_FILL);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FILL;
         lfsr      <= LOAD;
         fill_cnt  <= 3'd0;
         exp_idx   <= 3'd0;
         seq_err   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_index <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            pad[i] <= 8'h00;
         end
      end else if (resync) begin
         state     <= S_FILL;
         lfsr      <= LOAD;
         fill_cnt  <= 3'd0;
         exp_idx   <= 3'd0;
         seq_err   <= 1'b0;
         out_valid <= 1'b0;
      end else if (ena) begin
         case (state)
            S_FILL: begin
               pad[fill_cnt] <= lfsr;
               lfsr          <= lfsr_next;
               fill_cnt      <= fill_cnt + 3'd1;
               if (fill_cnt == 3'd7) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
               // A mismatched index still completes the handshake but is dropped.
               if (accept) begin
                  if (idx_ok) begin
                     out_data      <= in_data ^ pad[in_index];
                     out_index     <= in_index;
                     out_valid     <= 1'b1;
                     pad[in_index] <= lfsr;
                     lfsr          <= lfsr_next;
                     exp_idx       <= exp_idx + 3'd1;
                  end else begin
                     seq_err <= 1'b1;
                  end
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_otp_stream_decryptor.sv
// Directed bench for otp_stream_decryptor: vector table for the byte stream,
// hand-written sequences for fill, resync, backpressure, ena and async reset.
module tb_otp_stream_decryptor;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       resync;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_index;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_index;
   logic       seq_err;
   logic       busy;
   logic       dbg_state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      logic [2:0] idx;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic [2:0] exp_idx;
      logic       exp_err;
   } vec_t;

   vec_t vecs[17];

   otp_stream_decryptor #(.SEED(8'hA5), .TAPS(8'hB8)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .resync    (resync),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_index  (in_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .seq_err   (seq_err),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one table row, confirm it is accepted, then check the registered result.
   task automatic apply_row(input int i);
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_index = vecs[i].idx;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
         chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         chk($sformatf("row%0d out_index", i), 32'(out_index), 32'(vecs[i].exp_idx));
      end
      chk($sformatf("row%0d seq_err", i), 32'(seq_err), 32'(vecs[i].exp_err));
   endtask

   task automatic wait_fill(input string name, input int n);
      for (int k = 0; k < n; k++) begin
         #1;
         chk($sformatf("%s busy%0d", name, k), 32'(busy), 32'd1);
         chk($sformatf("%s in_ready%0d", name, k), 32'(in_ready), 32'd0);
         @(posedge clk);
      end
      #1;
      chk($sformatf("%s busy_done", name), 32'(busy), 32'd0);
      chk($sformatf("%s ready_done", name), 32'(in_ready), 32'd1);
   endtask

   initial begin
      // Pads from A5/B8: A5 4A 95 2A 54 A9 53 A7, then 4E 9D 3B ...
      vecs[0]  = '{8'h00, 3'd0, 1'b1, 8'hA5, 3'd0, 1'b0};
      vecs[1]  = '{8'hFF, 3'd1, 1'b1, 8'hB5, 3'd1, 1'b0};
      vecs[2]  = '{8'h95, 3'd2, 1'b1, 8'h00, 3'd2, 1'b0};
      vecs[3]  = '{8'h00, 3'd3, 1'b1, 8'h2A, 3'd3, 1'b0};
      vecs[4]  = '{8'h00, 3'd4, 1'b1, 8'h54, 3'd4, 1'b0};
      vecs[5]  = '{8'h00, 3'd5, 1'b1, 8'hA9, 3'd5, 1'b0};
      vecs[6]  = '{8'h00, 3'd6, 1'b1, 8'h53, 3'd6, 1'b0};
      vecs[7]  = '{8'h00, 3'd7, 1'b1, 8'hA7, 3'd7, 1'b0};
      vecs[8]  = '{8'h00, 3'd0, 1'b1, 8'h4E, 3'd0, 1'b0};
      vecs[9]  = '{8'h12, 3'd5, 1'b0, 8'h00, 3'd0, 1'b1};
      vecs[10] = '{8'h00, 3'd0, 1'b1, 8'hA5, 3'd0, 1'b0};
      vecs[11] = '{8'hFF, 3'd1, 1'b1, 8'hB5, 3'd1, 1'b0};
      vecs[12] = '{8'h12, 3'd3, 1'b0, 8'h00, 3'd0, 1'b1};
      vecs[13] = '{8'h95, 3'd2, 1'b1, 8'h00, 3'd2, 1'b1};
      vecs[14] = '{8'h00, 3'd3, 1'b1, 8'h2A, 3'd3, 1'b1};
      vecs[15] = '{8'h00, 3'd4, 1'b1, 8'h54, 3'd4, 1'b1};
      vecs[16] = '{8'h00, 3'd0, 1'b1, 8'hA5, 3'd0, 1'b0};

      rst       = 1'b1;
      ena       = 1'b1;
      resync    = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_index  = 3'd0;
      out_ready = 1'b1;
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data", 32'(out_data), 32'd0);
      chk("rst out_index", 32'(out_index), 32'd0);
      chk("rst seq_err", 32'(seq_err), 32'd0);
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst in_ready", 32'(in_ready), 32'd0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_fill("fill", 8);

      // Decrypt, run across the index wrap, then one out-of-sequence byte.
      for (int i = 0; i <= 9; i++) apply_row(i);

      // Resync with a valid byte present and ena low: it must not be taken.
      in_valid = 1'b1;
      in_data  = 8'h00;
      in_index = 3'd1;
      resync   = 1'b1;
      ena      = 1'b0;
      #1;
      chk("resync in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("resync out_valid", 32'(out_valid), 32'd0);
      chk("resync busy", 32'(busy), 32'd1);
      chk("resync seq_err", 32'(seq_err), 32'd0);
      resync   = 1'b0;
      ena      = 1'b1;
      in_valid = 1'b0;
      wait_fill("refill", 8);

      for (int i = 10; i <= 13; i++) apply_row(i);

      // Stall the consumer with a byte pending and another waiting.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h00;
      in_index  = 3'd3;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp in_ready%0d", k), 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("bp out_valid%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp out_data%0d", k), 32'(out_data), 32'h00);
         chk($sformatf("bp out_index%0d", k), 32'(out_index), 32'd2);
      end
      out_ready = 1'b1;
      for (int i = 14; i <= 15; i++) apply_row(i);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("drain out_valid", 32'(out_valid), 32'd0);

      // Restart fill and drop ena for three cycles in the middle of it.
      resync = 1'b1;
      @(posedge clk);
      #1;
      resync = 1'b0;
      for (int k = 0; k < 11; k++) begin
         ena = !(k >= 2 && k < 5);
         #1;
         chk($sformatf("enafill busy%0d", k), 32'(busy), 32'd1);
         chk($sformatf("enafill in_ready%0d", k), 32'(in_ready), 32'd0);
         @(posedge clk);
      end
      ena = 1'b1;
      #1;
      chk("enafill busy_done", 32'(busy), 32'd0);
      apply_row(16);
      in_valid = 1'b0;

      // ena low freezes the pending output even though the consumer is ready.
      ena = 1'b0;
      #1;
      chk("ena_low in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("ena_low out_valid", 32'(out_valid), 32'd1);
      chk("ena_low out_data", 32'(out_data), 32'hA5);

      // Asynchronous reset between clock edges with a byte pending.
      ena       = 1'b1;
      out_ready = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst out_data", 32'(out_data), 32'd0);
      chk("async rst busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
